// File: rtl/tcdm_banked_xbar_if.sv
// ---------------------------------------------------------------------------
// tcdm_banked_xbar_if
// Bundles the request, response and statistics signals of the banked TCDM.
//   req_valid_i / req_ready_o  : per-port request handshake (ready = grant)
//   req_write_i, req_addr_i    : access type and byte address per port
//   req_data_i, req_strb_i     : write data and byte enables per port
//   rsp_valid_o, rsp_data_o    : per-port response (data is 0 for writes)
//   clear_cnt_i, conflict_cnt_o: conflict counter clear / value
// Modports: slave = memory side, master = requester side.
// ---------------------------------------------------------------------------
interface tcdm_banked_xbar_if #(
    parameter int unsigned NumInp    = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 14
);
    logic [NumInp-1:0]                    req_valid_i;
    logic [NumInp-1:0]                    req_ready_o;
    logic [NumInp-1:0]                    req_write_i;
    logic [NumInp-1:0][AddrWidth-1:0]     req_addr_i;
    logic [NumInp-1:0][DataWidth-1:0]     req_data_i;
    logic [NumInp-1:0][DataWidth/8-1:0]   req_strb_i;
    logic [NumInp-1:0]                    rsp_valid_o;
    logic [NumInp-1:0][DataWidth-1:0]     rsp_data_o;
    logic                                 clear_cnt_i;
    logic [31:0]                          conflict_cnt_o;

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_data_i, req_strb_i, clear_cnt_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, conflict_cnt_o
    );

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_data_i, req_strb_i, clear_cnt_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, conflict_cnt_o
    );
endinterface

// File: rtl/tcdm_banked_xbar.sv
// ---------------------------------------------------------------------------
// tcdm_banked_xbar
// Word-interleaved multi-bank TCDM with a per-bank round-robin request
// crossbar, fixed-latency response pipeline and saturating conflict counter.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset (memory contents are kept)
//   bus   : tcdm_banked_xbar_if.slave (requests, grants, responses, counter)
// Requires NumBanks >= 2 so the bank field of the address is non-empty.
// ---------------------------------------------------------------------------
module tcdm_banked_xbar #(
    parameter int unsigned NumInp     = 4,
    parameter int unsigned NumBanks   = 8,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned BankDepth  = 256,
    parameter int unsigned MemLatency = 1,
    parameter int unsigned AddrWidth  = $clog2(NumBanks*BankDepth*DataWidth/8)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    tcdm_banked_xbar_if.slave  bus
);
    localparam int unsigned StrbW = DataWidth/8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned BankW = $clog2(NumBanks);
    localparam int unsigned RowW  = $clog2(BankDepth);
    localparam int unsigned IdxW  = (NumInp > 1) ? $clog2(NumInp) : 1;

    logic [NumInp-1:0][BankW-1:0]     w_bank;
    logic [NumInp-1:0][RowW-1:0]      w_row;
    logic [NumInp-1:0]                w_unused_ofs;
    logic [NumBanks-1:0][IdxW-1:0]    r_ptr;
    logic [NumBanks-1:0][IdxW-1:0]    w_win;
    logic [NumBanks-1:0]              w_act;
    logic [NumInp-1:0]                w_gnt;
    logic [NumBanks-1:0][RowW-1:0]    w_b_row;
    logic [NumBanks-1:0]              w_b_we;
    logic [NumBanks-1:0][DataWidth-1:0] w_b_wdata;
    logic [NumBanks-1:0][StrbW-1:0]   w_b_strb;
    logic [DataWidth-1:0]             r_mem [NumBanks][BankDepth];
    logic [NumBanks-1:0][DataWidth-1:0] r_rdata;
    logic [NumInp-1:0][MemLatency-1:0] r_vld;
    logic [NumInp-1:0]                r_wr0;
    logic [NumInp-1:0][BankW-1:0]     r_bank0;
    logic [NumInp-1:0][DataWidth-1:0] w_dat0;
    logic                             w_stall;
    logic [31:0]                      r_cnt;

    // Byte offset is dropped; bank index sits directly above it.
    always_comb begin
        w_bank       = '0;
        w_row        = '0;
        w_unused_ofs = '0;
        for (int i = 0; i < NumInp; i++) begin
            w_bank[i]       = bus.req_addr_i[i][OffW +: BankW];
            w_row[i]        = bus.req_addr_i[i][OffW+BankW +: RowW];
            w_unused_ofs[i] = ^bus.req_addr_i[i][OffW-1:0];
        end
    end

    // Per bank: first requesting input at or after the pointer wins.
    always_comb begin : p_arb
        logic [IdxW-1:0] k;
        k     = '0;
        w_gnt = '0;
        w_act = '0;
        w_win = '0;
        for (int b = 0; b < NumBanks; b++) begin
            for (int o = 0; o < NumInp; o++) begin
                k = IdxW'((int'(r_ptr[b]) + o) % int'(NumInp));
                if (!w_act[b] && bus.req_valid_i[k] && (w_bank[k] == BankW'(b))) begin
                    w_act[b] = 1'b1;
                    w_win[b] = k;
                    w_gnt[k] = 1'b1;
                end
            end
        end
    end

    assign bus.req_ready_o = w_gnt;

    always_comb begin
        w_b_row   = '0;
        w_b_we    = '0;
        w_b_wdata = '0;
        w_b_strb  = '0;
        for (int b = 0; b < NumBanks; b++) begin
            w_b_row[b]   = w_row[w_win[b]];
            w_b_we[b]    = bus.req_write_i[w_win[b]];
            w_b_wdata[b] = bus.req_data_i[w_win[b]];
            w_b_strb[b]  = bus.req_strb_i[w_win[b]];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else begin
            for (int b = 0; b < NumBanks; b++) begin
                if (w_act[b]) begin
                    r_ptr[b] <= (int'(w_win[b]) == int'(NumInp) - 1) ? '0 : w_win[b] + 1'b1;
                end
            end
        end
    end

    // Banks are not reset; a write lands at the edge, so a read granted in
    // the next cycle already sees it.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NumBanks; b++) begin
            if (w_act[b]) begin
                if (w_b_we[b]) begin
                    for (int y = 0; y < int'(StrbW); y++) begin
                        if (w_b_strb[b][y]) begin
                            r_mem[b][w_b_row[b]][8*y +: 8] <= w_b_wdata[b][8*y +: 8];
                        end
                    end
                end
                r_rdata[b] <= r_mem[b][w_b_row[b]];
            end
        end
    end

    // Stage 0 remembers which bank to take the read data from; only the
    // valid bit needs to travel the full latency since data is masked here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld   <= '0;
            r_wr0   <= '0;
            r_bank0 <= '0;
        end else begin
            for (int i = 0; i < NumInp; i++) begin
                r_vld[i][0] <= w_gnt[i];
                r_wr0[i]    <= bus.req_write_i[i];
                r_bank0[i]  <= w_bank[i];
                for (int s = 1; s < int'(MemLatency); s++) begin
                    r_vld[i][s] <= r_vld[i][s-1];
                end
            end
        end
    end

    always_comb begin
        w_dat0          = '0;
        bus.rsp_valid_o = '0;
        for (int i = 0; i < NumInp; i++) begin
            if (r_vld[i][0] && !r_wr0[i]) begin
                w_dat0[i] = r_rdata[r_bank0[i]];
            end
            bus.rsp_valid_o[i] = r_vld[i][MemLatency-1];
        end
    end

    if (MemLatency == 1) begin : g_lat1
        assign bus.rsp_data_o = w_dat0;
    end else begin : g_latn
        logic [NumInp-1:0][MemLatency-2:0][DataWidth-1:0] r_dat;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_dat <= '0;
            end else begin
                for (int i = 0; i < NumInp; i++) begin
                    r_dat[i][0] <= w_dat0[i];
                    for (int s = 1; s < int'(MemLatency) - 1; s++) begin
                        r_dat[i][s] <= r_dat[i][s-1];
                    end
                end
            end
        end

        always_comb begin
            bus.rsp_data_o = '0;
            for (int i = 0; i < NumInp; i++) begin
                bus.rsp_data_o[i] = r_dat[i][MemLatency-2];
            end
        end
    end

    assign w_stall = |(bus.req_valid_i & ~w_gnt);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (bus.clear_cnt_i) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != 32'hFFFF_FFFF)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign bus.conflict_cnt_o = r_cnt;
endmodule

// File: tb/tb_tcdm_banked_xbar.sv
// ---------------------------------------------------------------------------
// tb_tcdm_banked_xbar
// Directed bench for tcdm_banked_xbar: one instance at latency 1 and one at
// latency 3, each on its own interface and reset.
// ---------------------------------------------------------------------------
module tb_tcdm_banked_xbar;
    logic clk;
    logic rst1;
    logic rst3;
    int   n_chk;
    int   n_err;

    logic [63:0] bdata [4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                               64'h5555_AAAA_5555_AAAA, 64'hC001_D00D_CAFE_F00D};
    logic [13:0] baddr [4] = '{14'h0020, 14'h0028, 14'h0030, 14'h0038};
    logic [3:0]  exp_rdy [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    tcdm_banked_xbar_if bus1 ();
    tcdm_banked_xbar_if bus3 ();

    tcdm_banked_xbar #(.MemLatency(1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst1),
        .bus   (bus1.slave)
    );

    tcdm_banked_xbar #(.MemLatency(3)) u_dut3 (
        .clk_i (clk),
        .rst_i (rst3),
        .bus   (bus3.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle1();
        bus1.req_valid_i = '0;
        bus1.req_write_i = '0;
        bus1.req_addr_i  = '0;
        bus1.req_data_i  = '0;
        bus1.req_strb_i  = '0;
        bus1.clear_cnt_i = 1'b0;
    endtask

    task automatic idle3();
        bus3.req_valid_i = '0;
        bus3.req_write_i = '0;
        bus3.req_addr_i  = '0;
        bus3.req_data_i  = '0;
        bus3.req_strb_i  = '0;
        bus3.clear_cnt_i = 1'b0;
    endtask

    task automatic drv1(input int p, input bit wr, input logic [13:0] a,
                        input logic [63:0] d, input logic [7:0] s);
        bus1.req_valid_i[p] = 1'b1;
        bus1.req_write_i[p] = wr;
        bus1.req_addr_i[p]  = a;
        bus1.req_data_i[p]  = d;
        bus1.req_strb_i[p]  = s;
    endtask

    task automatic drv3(input int p, input bit wr, input logic [13:0] a,
                        input logic [63:0] d, input logic [7:0] s);
        bus3.req_valid_i[p] = 1'b1;
        bus3.req_write_i[p] = wr;
        bus3.req_addr_i[p]  = a;
        bus3.req_data_i[p]  = d;
        bus3.req_strb_i[p]  = s;
    endtask

    // Four back-to-back accesses from port 1 on the latency-3 instance;
    // the response to access k is due at the negedge k+3 of the loop.
    task automatic burst3(input bit wr);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n >= 3 && n <= 6) begin
                check(wr ? "burst_wr_vld" : "burst_rd_vld", 64'(bus3.rsp_valid_o), 64'b0010);
                check(wr ? "burst_wr_dat" : "burst_rd_dat", bus3.rsp_data_o[1],
                      wr ? 64'h0 : bdata[n-3]);
            end else begin
                check("burst_quiet", 64'(bus3.rsp_valid_o), 64'h0);
            end
            idle3();
            if (n < 4) begin
                drv3(1, wr, baddr[n], bdata[n], 8'hFF);
                #1 check("burst_rdy", 64'(bus3.req_ready_o), 64'b0010);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        clk   = 1'b0;
        rst1  = 1'b1;
        rst3  = 1'b1;
        n_chk = 0;
        n_err = 0;
        idle1();
        idle3();
        repeat (2) @(negedge clk);
        check("rst_vld1", 64'(bus1.rsp_valid_o), 64'h0);
        check("rst_dat1", bus1.rsp_data_o[0], 64'h0);
        check("rst_cnt1", 64'(bus1.conflict_cnt_o), 64'h0);
        check("rst_vld3", 64'(bus3.rsp_valid_o), 64'h0);
        check("rst_cnt3", 64'(bus3.conflict_cnt_o), 64'h0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        check("idle_rdy", 64'(bus1.req_ready_o), 64'h0);

        // Write then read, port 0, address 0x40 (bank 0, row 1)
        drv1(0, 1'b1, 14'h0040, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        #1 check("t1_wr_rdy", 64'(bus1.req_ready_o), 64'b0001);
        @(negedge clk);
        check("t1_wr_rsp_vld", 64'(bus1.rsp_valid_o), 64'b0001);
        check("t1_wr_rsp_dat", bus1.rsp_data_o[0], 64'h0);
        drv1(0, 1'b0, 14'h0040, 64'h0, 8'h00);
        #1 check("t1_rd_rdy", 64'(bus1.req_ready_o), 64'b0001);
        @(negedge clk);
        idle1();
        check("t1_rd_vld", 64'(bus1.rsp_valid_o), 64'b0001);
        check("t1_rd_dat", bus1.rsp_data_o[0], 64'hDEAD_BEEF_0123_4567);
        @(negedge clk);
        check("t1_one_cycle", 64'(bus1.rsp_valid_o), 64'h0);

        // Partial strobe on address 0x08 (cleared first)
        drv1(0, 1'b1, 14'h0008, 64'h0, 8'hFF);
        @(negedge clk);
        drv1(0, 1'b1, 14'h0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        @(negedge clk);
        drv1(0, 1'b0, 14'h0008, 64'h0, 8'h00);
        @(negedge clk);
        idle1();
        check("t2_vld", 64'(bus1.rsp_valid_o), 64'b0001);
        check("t2_dat", bus1.rsp_data_o[0], 64'h0000_0000_FFFF_FFFF);

        // Full conflict on bank 2: grants 0,1,2,3 on consecutive cycles
        @(negedge clk);
        check("t3_cnt0", 64'(bus1.conflict_cnt_o), 64'h0);
        for (int p = 0; p < 4; p++) drv1(p, 1'b0, 14'h0010, 64'h0, 8'h00);
        for (int c = 0; c < 4; c++) begin
            #1 check("t3_rdy", 64'(bus1.req_ready_o), 64'(exp_rdy[c]));
            @(negedge clk);
            check("t3_rsp_vld", 64'(bus1.rsp_valid_o), 64'(exp_rdy[c]));
            bus1.req_valid_i[c] = 1'b0;
        end
        check("t3_cnt", 64'(bus1.conflict_cnt_o), 64'd3);
        @(negedge clk);
        check("t3_cnt_hold", 64'(bus1.conflict_cnt_o), 64'd3);
        bus1.clear_cnt_i = 1'b1;
        @(negedge clk);
        bus1.clear_cnt_i = 1'b0;
        check("clr_cnt", 64'(bus1.conflict_cnt_o), 64'h0);

        // Parallel banks 0..3
        drv1(0, 1'b0, 14'h0000, 64'h0, 8'h00);
        drv1(1, 1'b0, 14'h0008, 64'h0, 8'h00);
        drv1(2, 1'b0, 14'h0010, 64'h0, 8'h00);
        drv1(3, 1'b0, 14'h0018, 64'h0, 8'h00);
        #1 check("t4_rdy", 64'(bus1.req_ready_o), 64'hF);
        @(negedge clk);
        idle1();
        check("t4_vld", 64'(bus1.rsp_valid_o), 64'hF);
        check("t4_dat1", bus1.rsp_data_o[1], 64'h0000_0000_FFFF_FFFF);
        check("t4_dat2", bus1.rsp_data_o[2], 64'h0);
        check("t4_cnt", 64'(bus1.conflict_cnt_o), 64'h0);

        // Bank 0 pointer now 1: port 2 (write) beats port 0 (read), then the
        // read from port 0 sees the data port 2 just wrote.
        @(negedge clk);
        drv1(0, 1'b0, 14'h0040, 64'h0, 8'h00);
        drv1(2, 1'b1, 14'h0040, 64'h1111_2222_3333_4444, 8'hFF);
        #1 check("t5_rdy_a", 64'(bus1.req_ready_o), 64'b0100);
        @(negedge clk);
        check("t5_vld_a", 64'(bus1.rsp_valid_o), 64'b0100);
        check("t5_dat_a", bus1.rsp_data_o[2], 64'h0);
        bus1.req_valid_i[2] = 1'b0;
        #1 check("t5_rdy_b", 64'(bus1.req_ready_o), 64'b0001);
        @(negedge clk);
        idle1();
        check("t5_vld_b", 64'(bus1.rsp_valid_o), 64'b0001);
        check("t5_dat_b", bus1.rsp_data_o[0], 64'h1111_2222_3333_4444);
        check("t5_cnt", 64'(bus1.conflict_cnt_o), 64'd1);

        // Latency 3, pipelined bursts on port 1
        burst3(1'b1);
        burst3(1'b0);

        // Reset mid-flight; bank 4 pointer is 2, so port 0 wins over port 1
        @(negedge clk);
        drv3(0, 1'b0, 14'h0020, 64'h0, 8'h00);
        drv3(1, 1'b0, 14'h0020, 64'h0, 8'h00);
        #1 check("t6_rdy", 64'(bus3.req_ready_o), 64'b0001);
        @(negedge clk);
        idle3();
        check("t6_cnt_pre", 64'(bus3.conflict_cnt_o), 64'd1);
        rst3 = 1'b1;
        #1 check("t6_rst_vld", 64'(bus3.rsp_valid_o), 64'h0);
        @(negedge clk);
        rst3 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("t6_no_rsp", 64'(bus3.rsp_valid_o), 64'h0);
        end
        check("t6_cnt_post", 64'(bus3.conflict_cnt_o), 64'h0);
        drv3(1, 1'b0, 14'h0020, 64'h0, 8'h00);
        #1 check("t6_rd_rdy", 64'(bus3.req_ready_o), 64'b0010);
        @(negedge clk);
        idle3();
        @(negedge clk);
        check("t6_rd_early", 64'(bus3.rsp_valid_o), 64'h0);
        @(negedge clk);
        check("t6_rd_vld", 64'(bus3.rsp_valid_o), 64'b0010);
        check("t6_rd_dat", bus3.rsp_data_o[1], bdata[0]);
        check("t6_cnt_end", 64'(bus3.conflict_cnt_o), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/tcdm_banked_xbar.md
# tcdm_banked_xbar

Multi-port, multi-bank tightly coupled data memory with an integrated request crossbar. It is the parametrised successor to the fixed two-port TCDM subsystem. Each input port issues word-wide read/write requests. Requests are interleaved across `NumBanks` single-port SRAM banks by address. Per-bank round-robin arbitration resolves conflicts, and responses return after a configurable fixed latency. A saturating conflict counter exposes bank-contention statistics to the testbench and to performance monitors.

## Interface
Parameters:
- `NumInp`, 4: number of requesting ports (1..16).
- `NumBanks`, 8: number of SRAM banks; power of two.
- `DataWidth`, 64: word width in bits; power of two, ≥ 32.
- `BankDepth`, 256: words per bank; power of two.
- `MemLatency`, 1: cycles from accept to response (1..4).
- `AddrWidth`, `$clog2(NumBanks*BankDepth*DataWidth/8)`: byte address width (14 at defaults).

Ports:
- `clk_i`, in, 1: clock; all logic is on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `req_valid_i`, in, `[NumInp]`: request valid.
- `req_ready_o`, out, `[NumInp]`: request accepted this cycle (the grant).
- `req_write_i`, in, `[NumInp]`: 1 = write, 0 = read.
- `req_addr_i`, in, `[NumInp][AddrWidth]`: byte address.
- `req_data_i`, in, `[NumInp][DataWidth]`: write data.
- `req_strb_i`, in, `[NumInp][DataWidth/8]`: byte enables for writes.
- `rsp_valid_o`, out, `[NumInp]`: response valid.
- `rsp_data_o`, out, `[NumInp][DataWidth]`: read data; 0 for write responses.
- `clear_cnt_i`, in, 1: synchronous clear of the conflict counter.
- `conflict_cnt_o`, out, 32: saturating count of stall cycles.

## Operation
**Address split**
- Low `$clog2(DataWidth/8)` bits: byte offset, ignored.
- Next `$clog2(NumBanks)` bits: bank index (word interleaving).
- Remaining bits: row within the bank.

**Arbitration**
- Each bank has a round-robin pointer, 0 at reset.
- Among inputs with valid set that target the bank, the first at or after the pointer wins.
- After a grant to input k, the pointer moves to (k+1) mod `NumInp`. With no grant, the pointer is unchanged.
- At most one access per bank per cycle. Different banks are served in parallel.
- `req_ready_o[i]` is combinational: 1 only if `req_valid_i[i]` is 1 and input i won its bank. It is never 1 while valid is 0.
- A stalled requester must hold valid, address, data and strobe stable until it is granted.

**Bank access**
- Write: only bytes with their strobe bit set are updated.
- Read: returns the full word.
- Bank contents are not reset; in simulation they initialise to zeros.

**Response pipeline**
- Per input, a `MemLatency`-deep shift register carries a valid bit and a write flag.
- Read data is captured from the bank that input was granted.
- There is no response backpressure; one response per accepted request, delivered in order.

**Conflict counter**
- Increments by 1 in any cycle where at least one valid request is not granted.
- Saturates at `0xFFFF_FFFF`.
- `clear_cnt_i` takes priority over increment: the counter reads 0 in the following cycle.

## Timing
- Request accepted at edge t (valid and ready both 1) produces `rsp_valid_o` high for exactly one cycle in cycle t+`MemLatency`.
- Fully pipelined: one accept per port per cycle and back-to-back responses.
- A write followed on the next cycle by a read to the same word, from any port, returns the new data.
- Reset values:
  - `rsp_valid_o` = 0, `rsp_data_o` = 0, `conflict_cnt_o` = 0.
  - All RR pointers = 0, all pipeline valids = 0.
  - `req_ready_o` follows the inputs combinationally.
- Reset asserted mid-operation: in-flight responses are discarded, and `rsp_valid_o` stays 0 until new requests are accepted after deassertion. Memory contents are retained.
- Simultaneous events:
  - Requests to the same bank with one read and one write: arbitration is unaffected by type.
  - Requests to the same word but different ports: the same bank conflict rules apply.

## Test plan
1. **Write then read.** Port 0 writes `0xDEADBEEF01234567` to address `0x0040` with strobe `0xFF`, then reads the same address. Required: write response has data 0; read response arrives 1 cycle after accept with `0xDEADBEEF01234567`.
2. **Partial strobe.** Write all-ones with strobe `0x0F` to zeroed address `0x0008`, then read it. Required: read data `0x00000000FFFFFFFF`.
3. **Full conflict.** After reset, ports 0..3 hold reads to address `0x0010` (bank 2). Required: grants to ports 0, 1, 2, 3 on consecutive cycles; `conflict_cnt_o` equals 3.
4. **Parallel banks.** Ports 0..3 read addresses `0x00`, `0x08`, `0x10`, `0x18` (banks 0..3) in the same cycle. Required: all ready in that cycle; four responses in the same later cycle; counter unchanged.
5. **Latency 3, pipelined.** With `MemLatency`=3, port 1 issues 4 back-to-back reads. Required: `rsp_valid_o[1]` high in cycles t+3..t+6 with the data in order.
6. **Reset mid-flight.** With `MemLatency`=3, assert `rst_i` one cycle after a read is accepted. Required: no response appears. After reset, a read of a previously written word returns the old value; counter is 0.
